fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction-fetch controller sitting directly downstream of the 16-bit PC register and looping back into it. Reads the current PC, runs a req/ack handshake with instruction memory, and holds the fetched word in a one-entry IF/ID buffer for decode. Computes the next PC (sequential or branch target) and pulses the PC write strobe for one cycle. Supports halt (stop new fetches) and branch flush.

Parameters:
PC_INC, 1, increment added to the PC for sequential fetch (word-addressed memory); sum is taken modulo 2^16.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  asynchronous, active-low reset.
pc_in  input  16  current PC register contents.
pc_next  output  16  next-PC value to the PC register data input.
pc_wrt  output  1  PC write strobe; one-cycle pulse.
imem_req  output  1  instruction-memory read request (registered).
imem_addr  output  16  instruction-memory address (registered); stable while imem_req=1.
imem_ack  input  1  memory ack; imem_rdata valid in the same cycle.
imem_rdata  input  16  instruction word from memory.
ir_out  output  16  buffered instruction to decode.
ir_pc  output  16  PC of ir_out.
ir_valid  output  1  buffer holds a valid instruction.
id_ready  input  1  decode accepts ir_out at this posedge when ir_valid=1.
branch_taken  input  1  single-cycle branch/jump request from execute.
branch_target  input  16  branch destination; valid with branch_taken.
halt  input  1  level; when high, no new fetch is issued.

Behaviour:
- Reset (rst=0, async): state=IDLE; pc_next, imem_addr, ir_out, ir_pc = 0x0000; pc_wrt, imem_req, ir_valid = 0.
- slot_free = !ir_valid || id_ready. A transfer occurs at a posedge with ir_valid && id_ready; it clears ir_valid unless a capture happens at the same edge.
- IDLE: go to ISSUE on the next edge.
- ISSUE: imem_req=0. If branch_taken: pc_next<=branch_target, go to UPD. Else if !halt && slot_free: imem_req<=1, imem_addr<=pc_in, go to WAIT. Otherwise stay in ISSUE.
- WAIT: imem_req and imem_addr are held.
  - ack && !branch_taken: ir_out<=imem_rdata, ir_pc<=imem_addr, ir_valid<=1, pc_next<=imem_addr+PC_INC, imem_req<=0, go to UPD.
  - ack && branch_taken: branch wins; data discarded, pc_next<=branch_target, imem_req<=0, go to UPD.
  - branch_taken && !ack: pc_next<=branch_target, go to DRAIN with the request still held.
- DRAIN: imem_req held until ack. On ack: discard data, imem_req<=0, go to UPD. A further branch_taken in DRAIN overwrites pc_next.
- UPD: pc_wrt=1 for exactly this cycle (decoded from state); imem_req=0. Go to ISSUE. If branch_taken in UPD: pc_next<=branch_target and stay in UPD one more cycle (pc_wrt high again).
- Branch flush: branch_taken in any non-reset state forces ir_valid<=0 at that edge, overriding transfer and capture.
- Halt: affects ISSUE only. An outstanding request always completes. Branch has priority over halt.
- Handshake rule: once imem_req rises it stays high with constant imem_addr until the cycle of ack.
- Arithmetic: 16-bit wrap, e.g. 0xFFFF+1 = 0x0000.
- Timing: minimum 3 cycles per instruction (ISSUE, WAIT with zero-wait ack, UPD). Each extra memory wait cycle adds 1.
- Mid-operation reset: all outputs return to reset values immediately; any pending ack is ignored.

Optional Feature:
FETCH_TRACE_EN: when defined, each capture prints a simulation $display with the fetched PC and instruction in hex. When undefined, nothing is printed. RTL behaviour is identical either way.

Test Plan:
- Reset release with pc_in=0x0000, imem_rdata=0x1234, ack in the first WAIT cycle -> imem_addr=0x0000; ir_out=0x1234, ir_pc=0x0000, ir_valid=1; pc_next=0x0001 with a one-cycle pc_wrt; next request at 0x0001 (PC model in bench).
- Memory ack delayed 3 cycles -> imem_req and imem_addr stay constant for 4 cycles; exactly one capture; exactly one pc_wrt pulse.
- id_ready=0 with ir_valid=1 -> no new imem_req issued; raise id_ready -> transfer, then request at the next PC.
- branch_taken with target 0x0040 during WAIT, ack 2 cycles later -> returned data discarded; ir_valid=0; pc_next=0x0040; pc_wrt pulses once after ack; next fetch at 0x0040.
- pc_in=0xFFFF fetched -> pc_next=0x0000; simultaneous ack and branch_taken (target 0x0100) -> pc_next=0x0100 and no capture.
- halt=1 in ISSUE for 5 cycles -> imem_req stays 0; deassert -> request issues on the following edge. rst pulsed low mid-WAIT -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch controller between the PC register and decode. It reads the
// current PC, runs a req/ack read against instruction memory, buffers the
// fetched word in a one-entry IF/ID register and writes the next PC back to the
// PC register (sequential PC+PC_INC, or a branch target) with a one-cycle
// strobe. Supports halt (no new fetch issued) and branch flush.
//
// Optional build macro:
//   FETCH_TRACE_EN - when defined, each capture prints the fetched PC and
//                    instruction (simulation only). Hardware is identical
//                    either way.
//
// Ports:
//   clk            in   clock, all state on posedge
//   rst            in   asynchronous active-low reset
//   pc_in[15:0]    in   current PC register contents
//   pc_next[15:0]  out  data input of the PC register
//   pc_wrt         out  PC register write strobe (high for each UPD cycle)
//   imem_req       out  memory read request (registered)
//   imem_addr[15:0]out  memory address (registered)
//   imem_ack       in   memory acknowledge, imem_rdata valid in same cycle
//   imem_rdata[15:0]in  instruction word from memory
//   ir_out[15:0]   out  buffered instruction for decode
//   ir_pc[15:0]    out  PC of ir_out
//   ir_valid       out  ir_out/ir_pc hold a valid instruction
//   id_ready       in   decode accepts ir_out at this edge when ir_valid=1
//   branch_taken   in   single-cycle redirect request from execute
//   branch_target  in   redirect destination, valid with branch_taken
//   halt           in   level; blocks issue of new fetches
//   state_o[2:0]   out  current FSM state (debug observation)
//
// Handshakes:
//   imem: once imem_req rises it stays high with a constant imem_addr up to and
//   including the cycle in which imem_ack is seen; the request drops on the
//   edge that samples the ack. IF/ID: a transfer happens on every edge where
//   ir_valid && id_ready; ir_valid/ir_out/ir_pc are registered and only change
//   on an edge.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [15:0] PC_INC = 16'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_in,
  output logic [15:0] pc_next,
  output logic        pc_wrt,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] ir_out,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  input  logic        id_ready,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        halt,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_UPD   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_next_q, pc_next_d;
  logic        imem_req_q, imem_req_d;
  logic [15:0] imem_addr_q, imem_addr_d;
  logic [15:0] ir_out_q, ir_out_d;
  logic [15:0] ir_pc_q, ir_pc_d;
  logic        ir_valid_q, ir_valid_d;
  logic        slot_free;

  // The buffer can take a new word if it is empty or is being drained now.
  assign slot_free = !ir_valid_q || id_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_next_q   <= 16'h0000;
      imem_req_q  <= 1'b0;
      imem_addr_q <= 16'h0000;
      ir_out_q    <= 16'h0000;
      ir_pc_q     <= 16'h0000;
      ir_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_next_q   <= pc_next_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      ir_out_q    <= ir_out_d;
      ir_pc_q     <= ir_pc_d;
      ir_valid_q  <= ir_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_next_d   = pc_next_q;
    imem_req_d  = imem_req_q;
    imem_addr_d = imem_addr_q;
    ir_out_d    = ir_out_q;
    ir_pc_d     = ir_pc_q;
    ir_valid_d  = ir_valid_q;

    // Decode transfer; a capture below may set the buffer valid again.
    if (ir_valid_q && id_ready) begin
      ir_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_ISSUE;
      end

      S_ISSUE: begin
        imem_req_d = 1'b0;
        if (branch_taken) begin
          pc_next_d = branch_target;
          state_d   = S_UPD;
        end else if (!halt && slot_free) begin
          imem_req_d  = 1'b1;
          imem_addr_d = pc_in;
          state_d     = S_WAIT;
        end
      end

      S_WAIT: begin
        if (imem_ack) begin
          imem_req_d = 1'b0;
          state_d    = S_UPD;
          if (branch_taken) begin
            pc_next_d = branch_target;
          end else begin
            ir_out_d   = imem_rdata;
            ir_pc_d    = imem_addr_q;
            ir_valid_d = 1'b1;
            pc_next_d  = imem_addr_q + PC_INC;
          end
        end else if (branch_taken) begin
          // The request cannot be withdrawn; finish it and drop the data.
          pc_next_d = branch_target;
          state_d   = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (branch_taken) begin
          pc_next_d = branch_target;
        end
        if (imem_ack) begin
          imem_req_d = 1'b0;
          state_d    = S_UPD;
        end
      end

      S_UPD: begin
        imem_req_d = 1'b0;
        if (branch_taken) begin
          // Re-write the PC with the new target on the next cycle.
          pc_next_d = branch_target;
          state_d   = S_UPD;
        end else begin
          state_d = S_ISSUE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flush wins over both transfer and capture.
    if (branch_taken) begin
      ir_valid_d = 1'b0;
    end
  end

  assign pc_next   = pc_next_q;
  assign pc_wrt    = (state_q == S_UPD);
  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign ir_out    = ir_out_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;
  assign state_o   = state_q;

`ifdef FETCH_TRACE_EN
  always @(posedge clk) begin
    if (rst && state_q == S_WAIT && imem_ack && !branch_taken) begin
      $display("[fetch_unit] fetch pc=%h instr=%h", imem_addr_q, imem_rdata);
    end
  end
`else
  // Trace output disabled.
`endif

endmodule
